// File: rtl/motion_zone_tracker.sv
// motion_zone_tracker: accumulates motion pixels in the left and right paddle
// zones over each camera frame, then divides row sum by pixel count serially
// to publish one mean paddle row per zone per frame.
// Optional feature: define MOTION_ZONE_SMOOTH_EN to average each accepted
// result with the previous position to damp paddle jitter.
module motion_zone_tracker #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int ZONE_W     = 160,
   parameter int MIN_PIXELS = 64,
   parameter int Y_W        = 10,
   parameter int CNT_W      = 17,
   parameter int SUM_W      = 27
) (
   input  logic           iCLK,
   input  logic           iRST_N,
   input  logic           iFVAL,
   input  logic           iDVAL,
   input  logic [10:0]    iX,
   input  logic [Y_W-1:0] iY,
   input  logic           iMOTION,
   output logic [Y_W-1:0] oLEFT_Y,
   output logic [Y_W-1:0] oRIGHT_Y,
   output logic           oLEFT_ACT,
   output logic           oRIGHT_ACT,
   output logic           oVALID,
   output logic           oDROP
);

   typedef enum logic [1:0] {IDLE, DIV_L, DIV_R, UPDATE} state_t;

   localparam int              STEP_W      = $clog2(Y_W);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(Y_W - 1);
   localparam logic [Y_W-1:0]  POS_RESET   = Y_W'(V_ACTIVE / 2);
   localparam logic [Y_W-1:0]  POS_MAX     = Y_W'(V_ACTIVE - 1);
   localparam logic [10:0]     LEFT_END    = 11'(ZONE_W);
   localparam logic [10:0]     RIGHT_START = 11'(H_ACTIVE - ZONE_W);
   localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(MIN_PIXELS);

   state_t              state_q, state_d;
   logic                fval_q;
   logic [CNT_W-1:0]    cnt_l, cnt_r, snap_cnt_l, snap_cnt_r;
   logic [SUM_W-1:0]    sum_l, sum_r, snap_sum_r;
   logic [SUM_W-1:0]    rem_q, dvsr_q, rem_next;
   logic [Y_W-1:0]      quo_q, quo_next, quo_l, quo_r;
   logic [STEP_W-1:0]   step_q;
   logic                rem_ge;
   logic                frame_start, frame_end, hit_l, hit_r;
   logic                acc_l, acc_r;
   logic [Y_W-1:0]      clamp_l, clamp_r, next_l_y, next_r_y;

   // Saturating counter increment: stays at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // Saturating row-sum accumulate.
   function automatic logic [SUM_W-1:0] sum_add(input logic [SUM_W-1:0] s,
                                                input logic [Y_W-1:0] y);
      logic [SUM_W:0] t;
      t = {1'b0, s} + (SUM_W+1)'(y);
      return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
   endfunction

   // Limit a quotient to the last visible row.
   function automatic logic [Y_W-1:0] clamp_row(input logic [Y_W-1:0] q);
      return (q > POS_MAX) ? POS_MAX : q;
   endfunction

`ifdef MOTION_ZONE_SMOOTH_EN
   // Rounded average of old and new position, one bit wider to avoid overflow.
   function automatic logic [Y_W-1:0] smooth(input logic [Y_W-1:0] old_y,
                                             input logic [Y_W-1:0] new_y);
      return Y_W'(({1'b0, old_y} + {1'b0, new_y} + (Y_W+1)'(1)) >> 1);
   endfunction
`endif

   assign frame_start = iFVAL & ~fval_q;
   assign frame_end   = ~iFVAL & fval_q;
   assign hit_l       = iFVAL & iDVAL & iMOTION & (iX < LEFT_END);
   assign hit_r       = iFVAL & iDVAL & iMOTION & (iX >= RIGHT_START);

   // Per-zone pixel count and row sum; cleared at frame start, keeping a same-cycle pixel.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         fval_q <= 1'b0;
         cnt_l  <= '0;
         cnt_r  <= '0;
         sum_l  <= '0;
         sum_r  <= '0;
      end else begin
         fval_q <= iFVAL;
         if (frame_start) begin
            cnt_l <= hit_l ? CNT_W'(1) : '0;
            sum_l <= hit_l ? SUM_W'(iY) : '0;
            cnt_r <= hit_r ? CNT_W'(1) : '0;
            sum_r <= hit_r ? SUM_W'(iY) : '0;
         end else begin
            if (hit_l) begin
               cnt_l <= cnt_inc(cnt_l);
               sum_l <= sum_add(sum_l, iY);
            end
            if (hit_r) begin
               cnt_r <= cnt_inc(cnt_r);
               sum_r <= sum_add(sum_r, iY);
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic: one pass of Y_W steps per zone, then a single update cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (frame_end) state_d = DIV_L;
         DIV_L:   if (step_q == LAST_STEP) state_d = DIV_R;
         DIV_R:   if (step_q == LAST_STEP) state_d = UPDATE;
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // One restoring-division step plus the accept/clamp/smooth decisions for UPDATE.
   always_comb begin
      rem_ge   = (rem_q >= dvsr_q);
      rem_next = rem_ge ? (rem_q - dvsr_q) : rem_q;
      quo_next = {quo_q[Y_W-2:0], rem_ge};
      acc_l    = (snap_cnt_l >= MIN_CNT);
      acc_r    = (snap_cnt_r >= MIN_CNT);
      clamp_l  = clamp_row(quo_l);
      clamp_r  = clamp_row(quo_r);
`ifdef MOTION_ZONE_SMOOTH_EN
      next_l_y = smooth(oLEFT_Y, clamp_l);
      next_r_y = smooth(oRIGHT_Y, clamp_r);
`else
      next_l_y = clamp_l;
      next_r_y = clamp_r;
`endif
   end

   // Divider datapath: snapshot at frame end, the shifted divisor walks down one bit per cycle.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         snap_cnt_l <= '0;
         snap_cnt_r <= '0;
         snap_sum_r <= '0;
         rem_q      <= '0;
         dvsr_q     <= '0;
         quo_q      <= '0;
         quo_l      <= '0;
         quo_r      <= '0;
         step_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (frame_end) begin
                  snap_cnt_l <= cnt_l;
                  snap_cnt_r <= cnt_r;
                  snap_sum_r <= sum_r;
                  rem_q      <= sum_l;
                  dvsr_q     <= SUM_W'(cnt_l) << (Y_W - 1);
                  quo_q      <= '0;
                  step_q     <= '0;
               end
            end
            DIV_L: begin
               if (step_q == LAST_STEP) begin
                  quo_l  <= quo_next;
                  rem_q  <= snap_sum_r;
                  dvsr_q <= SUM_W'(snap_cnt_r) << (Y_W - 1);
                  quo_q  <= '0;
                  step_q <= '0;
               end else begin
                  rem_q  <= rem_next;
                  dvsr_q <= dvsr_q >> 1;
                  quo_q  <= quo_next;
                  step_q <= step_q + STEP_W'(1);
               end
            end
            DIV_R: begin
               if (step_q == LAST_STEP) begin
                  quo_r  <= quo_next;
                  step_q <= '0;
               end else begin
                  rem_q  <= rem_next;
                  dvsr_q <= dvsr_q >> 1;
                  quo_q  <= quo_next;
                  step_q <= step_q + STEP_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Registered outputs: positions/flags change only in UPDATE, strobes last one cycle.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         oLEFT_Y    <= POS_RESET;
         oRIGHT_Y   <= POS_RESET;
         oLEFT_ACT  <= 1'b0;
         oRIGHT_ACT <= 1'b0;
         oVALID     <= 1'b0;
         oDROP      <= 1'b0;
      end else begin
         oVALID <= (state_q == UPDATE);
         oDROP  <= frame_end && (state_q != IDLE);
         if (state_q == UPDATE) begin
            oLEFT_ACT  <= acc_l;
            oRIGHT_ACT <= acc_r;
            if (acc_l) oLEFT_Y  <= next_l_y;
            if (acc_r) oRIGHT_Y <= next_r_y;
         end
      end
   end

endmodule

// File: tb/tb_motion_zone_tracker.sv
// tb_motion_zone_tracker: table-driven frames, hand-written reset/drop
// sequences and randomized frames checked against a per-frame reference model.
module tb_motion_zone_tracker;

   localparam int Y_W        = 10;
   localparam int V_ACTIVE   = 480;
   localparam int MIN_PIXELS = 64;
   localparam int LAT        = 2 * Y_W + 1;

   logic           iCLK = 1'b0;
   logic           iRST_N = 1'b0;
   logic           iFVAL = 1'b0;
   logic           iDVAL = 1'b0;
   logic [10:0]    iX = '0;
   logic [Y_W-1:0] iY = '0;
   logic           iMOTION = 1'b0;
   logic [Y_W-1:0] oLEFT_Y, oRIGHT_Y;
   logic           oLEFT_ACT, oRIGHT_ACT, oVALID, oDROP;

   int n_checks = 0;
   int n_pass   = 0;
   int valid_count = 0;
   int drop_count  = 0;

   typedef struct {
      int x;
      int y;
      bit dval;
      bit motion;
   } pix_t;

   typedef struct {
      int xa;
      int xb;
      int y0;
      int n;
      bit l_act;
      int l_pos;
      bit r_act;
      int r_pos;
   } vec_t;

   pix_t frame_q[$];
   vec_t vecs[7];

   int exp_l_y = 240;
   int exp_r_y = 240;
   int exp_l_act = 0;
   int exp_r_act = 0;

`ifdef MOTION_ZONE_SMOOTH_EN
   localparam bit SMOOTH = 1'b1;
`else
   localparam bit SMOOTH = 1'b0;
`endif

   motion_zone_tracker dut (
      .iCLK       (iCLK),
      .iRST_N     (iRST_N),
      .iFVAL      (iFVAL),
      .iDVAL      (iDVAL),
      .iX         (iX),
      .iY         (iY),
      .iMOTION    (iMOTION),
      .oLEFT_Y    (oLEFT_Y),
      .oRIGHT_Y   (oRIGHT_Y),
      .oLEFT_ACT  (oLEFT_ACT),
      .oRIGHT_ACT (oRIGHT_ACT),
      .oVALID     (oVALID),
      .oDROP      (oDROP)
   );

   // 100 MHz pixel clock.
   always #5 iCLK = ~iCLK;

   // Count every strobe cycle seen on the outputs.
   always @(posedge iCLK) begin
      #1;
      if (oVALID === 1'b1) valid_count++;
      if (oDROP === 1'b1) drop_count++;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   function automatic int accept(input int old_y, input int new_y);
      return SMOOTH ? (old_y + new_y + 1) / 2 : new_y;
   endfunction

   // Reference model: a zone's result is its integer mean row over the whole frame.
   task automatic modelFrame();
      int cl, cr, sl, sr, m;
      cl = 0; cr = 0; sl = 0; sr = 0;
      foreach (frame_q[i]) begin
         if (frame_q[i].dval && frame_q[i].motion) begin
            if (frame_q[i].x < 160) begin
               cl++;
               sl += frame_q[i].y;
            end else if (frame_q[i].x >= 480) begin
               cr++;
               sr += frame_q[i].y;
            end
         end
      end
      exp_l_act = (cl >= MIN_PIXELS) ? 1 : 0;
      exp_r_act = (cr >= MIN_PIXELS) ? 1 : 0;
      if (exp_l_act == 1) begin
         m = sl / cl;
         if (m > V_ACTIVE - 1) m = V_ACTIVE - 1;
         exp_l_y = accept(exp_l_y, m);
      end
      if (exp_r_act == 1) begin
         m = sr / cr;
         if (m > V_ACTIVE - 1) m = V_ACTIVE - 1;
         exp_r_y = accept(exp_r_y, m);
      end
   endtask

   // Play frame_q as one frame (one pixel per cycle), leaving iFVAL low for the end edge.
   task automatic applyStimulus();
      iFVAL = 1'b1;
      foreach (frame_q[i]) begin
         iDVAL   = frame_q[i].dval;
         iMOTION = frame_q[i].motion;
         iX      = 11'(frame_q[i].x);
         iY      = Y_W'(frame_q[i].y);
         tick();
      end
      iFVAL   = 1'b0;
      iDVAL   = 1'b0;
      iMOTION = 1'b0;
   endtask

   task automatic checkResult(input string tag);
      checkOutput({tag, " left_y"},    int'(oLEFT_Y),    exp_l_y);
      checkOutput({tag, " left_act"},  int'(oLEFT_ACT),  exp_l_act);
      checkOutput({tag, " right_y"},   int'(oRIGHT_Y),   exp_r_y);
      checkOutput({tag, " right_act"}, int'(oRIGHT_ACT), exp_r_act);
   endtask

   // Wait for the result strobe after the frame-end edge and check the published values.
   task automatic waitResult(input string tag);
      int lat, v0;
      v0  = valid_count;
      lat = -1;
      tick();
      for (int c = 1; c <= LAT + 10; c++) begin
         tick();
         if (oVALID === 1'b1) begin
            lat = c;
            break;
         end
      end
      checkOutput({tag, " latency"}, lat, LAT);
      checkResult(tag);
      tick();
      tick();
      checkOutput({tag, " valid pulses"}, valid_count - v0, 1);
   endtask

   task automatic columnFrame(input int x, input int y0, input int n);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back('{x, y0 + i, 1'b1, 1'b1});
   endtask

   initial begin
      int lat, v0, n, r, x;

      // Each vector: n rows starting at y0, one pixel at column xa and one at xb per row.
      vecs[0] = '{300, 300, 100, 100, 1'b0,   0, 1'b0,   0};
      vecs[1] = '{ 10, 300, 100, 100, 1'b1, 149, 1'b0,   0};
      vecs[2] = '{600, 300, 400,  64, 1'b0,   0, 1'b1, 431};
      vecs[3] = '{600, 300, 400,  63, 1'b0,   0, 1'b0,   0};
      vecs[4] = '{159, 160,   0,  64, 1'b1,  31, 1'b0,   0};
      vecs[5] = '{479, 480, 200, 100, 1'b0,   0, 1'b1, 249};
      vecs[6] = '{ 10, 300, 600,  64, 1'b1, 479, 1'b0,   0};

      // Power-on reset.
      iRST_N = 1'b0;
      repeat (3) tick();
      checkResult("reset");
      checkOutput("reset valid", int'(oVALID), 0);
      checkOutput("reset drop", int'(oDROP), 0);
      iRST_N = 1'b1;
      tick();

      // Table-driven frames.
      foreach (vecs[v]) begin
         frame_q.delete();
         for (int i = 0; i < vecs[v].n; i++) begin
            frame_q.push_back('{vecs[v].xa, vecs[v].y0 + i, 1'b1, 1'b1});
            frame_q.push_back('{vecs[v].xb, vecs[v].y0 + i, 1'b1, 1'b1});
         end
         if (vecs[v].l_act) exp_l_y = accept(exp_l_y, vecs[v].l_pos);
         if (vecs[v].r_act) exp_r_y = accept(exp_r_y, vecs[v].r_pos);
         exp_l_act = vecs[v].l_act ? 1 : 0;
         exp_r_act = vecs[v].r_act ? 1 : 0;
         applyStimulus();
         waitResult($sformatf("vec%0d", v));
         repeat (3) tick();
      end

      // Mean 100 then mean 201 on the left zone (65 pixels each).
      columnFrame(10, 68, 65);
      exp_l_y = accept(exp_l_y, 100);
      exp_l_act = 1; exp_r_act = 0;
      applyStimulus();
      waitResult("smooth_a");
      columnFrame(10, 169, 65);
      exp_l_y = accept(exp_l_y, 201);
      applyStimulus();
      waitResult("smooth_b");
      repeat (3) tick();

      // Second frame-end edge 5 clocks after the first one, while the divider is busy.
      columnFrame(10, 100, 100);
      modelFrame();
      v0 = valid_count;
      applyStimulus();
      tick();
      tick();
      tick();
      iFVAL = 1'b1;
      tick();
      tick();
      checkOutput("drop early", int'(oDROP), 0);
      iFVAL = 1'b0;
      tick();
      checkOutput("drop strobe", int'(oDROP), 1);
      tick();
      checkOutput("drop width", int'(oDROP), 0);
      lat = -1;
      for (int c = 7; c <= LAT + 10; c++) begin
         tick();
         if (oVALID === 1'b1) begin
            lat = c;
            break;
         end
      end
      checkOutput("drop first latency", lat, LAT);
      checkResult("drop first");
      repeat (4) tick();
      checkOutput("drop valid pulses", valid_count - v0, 1);

      // Reset held 3 clocks in the middle of a frame; the rest of the frame is accumulated.
      iFVAL = 1'b1;
      for (int i = 0; i < 50; i++) begin
         iDVAL = 1'b1; iMOTION = 1'b1; iX = 11'd10; iY = Y_W'(i);
         tick();
      end
      iRST_N = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iX = 11'd600; iY = Y_W'(400 + i);
         tick();
      end
      iRST_N = 1'b1;
      iDVAL = 1'b0;
      exp_l_y = 240; exp_r_y = 240; exp_l_act = 0; exp_r_act = 0;
      checkResult("midframe reset");
      checkOutput("midframe reset valid", int'(oVALID), 0);
      columnFrame(10, 300, 64);
      modelFrame();
      applyStimulus();
      waitResult("post reset frame");
      repeat (3) tick();

      // Reset while the divider is running: the result must never appear.
      columnFrame(10, 0, 100);
      applyStimulus();
      tick();
      repeat (8) tick();
      iRST_N = 1'b0;
      tick();
      iRST_N = 1'b1;
      exp_l_y = 240; exp_r_y = 240; exp_l_act = 0; exp_r_act = 0;
      checkResult("div reset");
      v0 = valid_count;
      repeat (30) tick();
      checkOutput("div reset no valid", valid_count - v0, 0);

      // Randomized frames against the reference model.
      for (int f = 0; f < 8; f++) begin
         frame_q.delete();
         n = $urandom_range(150, 600);
         for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 3);
            case (r)
               0:       x = $urandom_range(0, 159);
               1:       x = $urandom_range(480, 639);
               2:       x = $urandom_range(160, 479);
               default: x = $urandom_range(0, 639);
            endcase
            frame_q.push_back('{x, $urandom_range(0, 479),
                                ($urandom_range(0, 7) != 0), ($urandom_range(0, 1) == 1)});
         end
         modelFrame();
         applyStimulus();
         waitResult($sformatf("rand%0d", f));
         repeat ($urandom_range(1, 5)) tick();
      end

      checkOutput("total drop pulses", drop_count, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
